// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Round-robin arbiter sharing one rv_mem-style memory port between NUM_REQ
//   requesters. The issued request sits in a registered output stage. Read
//   responses return in issue order and are steered back to the requester
//   that issued them by an in-order FIFO of requester IDs.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester request handshake
//   req_write           per-requester op (1 = write, 0 = read)
//   req_addr/req_data   packed per-requester address / write data (slice i = requester i)
//   resp_valid/ready    per-requester read-response handshake (resp_valid one-hot or zero)
//   resp_data           read data, broadcast to all requesters
//   mem_valid/ready     memory request handshake
//   mem_write/addr/data memory request payload
//   mem_resp_valid/ready/data  memory read-data return, in issue order
//   err                 sticky flag: read data arrived with nothing outstanding
module rv_mem_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PENDING_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           mem_valid,
  input  logic                           mem_ready,
  output logic                           mem_write,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_data,
  input  logic                           mem_resp_valid,
  output logic                           mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]          mem_resp_data,
  output logic                           err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(PENDING_DEPTH);
  localparam int CW  = PW + 1;

  // Output stage registers
  logic                  vld_p0;
  logic                  write_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  // Arbitration and pending-read bookkeeping
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] fifo_q [PENDING_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           err_q;

  logic [NUM_REQ-1:0]    elig;
  logic                  found;
  logic [IDW-1:0]        gidx;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  load;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  spurious;
  logic                  nonempty;
  logic [IDW-1:0]        head;
  logic                  head_ready;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + IDW'(1);
  endfunction

  // Eligibility uses the registered count only, so a pop this cycle never
  // opens a slot for a read competing in the same cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (req_write[i] || (count < CW'(PENDING_DEPTH)));
    end
  end

  // Winner is the eligible requester with the smallest upward distance from
  // rr_ptr; scanning by requester keeps every slice index constant.
  always_comb begin
    int best;
    int d;
    best      = NUM_REQ;
    d         = 0;
    found     = 1'b0;
    gidx      = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQ;
      if (elig[i] && (d < best)) begin
        best      = d;
        found     = 1'b1;
        gidx      = IDW'(i);
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign load   = !vld_p0 || mem_ready;
  assign accept = found && load;
  assign push   = accept && !sel_write;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (gidx == IDW'(i));
    end
  end

  // Response routing: purely combinational from the FIFO head
  assign nonempty = (count != '0);
  assign head     = fifo_q[rd_ptr];

  always_comb begin
    resp_valid = '0;
    head_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head == IDW'(i)) begin
        resp_valid[i] = mem_resp_valid && nonempty;
        head_ready    = resp_ready[i];
      end
    end
  end

  // With nothing outstanding the memory is always drained so stray data
  // cannot stall the return channel.
  assign mem_resp_ready = nonempty ? head_ready : 1'b1;
  assign resp_data      = mem_resp_data;
  assign pop            = mem_resp_valid && nonempty && head_ready;
  assign spurious       = mem_resp_valid && !nonempty;

  // Stage p0: request register and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      write_p0 <= 1'b0;
      addr_p0  <= '0;
      data_p0  <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        vld_p0 <= found;
        if (found) begin
          write_p0 <= sel_write;
          addr_p0  <= sel_addr;
          data_p0  <= sel_data;
          rr_ptr   <= wrap_inc(gidx);
        end
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (spurious) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= gidx;
  end

  assign mem_valid = vld_p0;
  assign mem_write = write_p0;
  assign mem_addr  = addr_p0;
  assign mem_data  = data_p0;
  assign err       = err_q;

endmodule
